// File: rtl/tow_game_core.sv
// ---------------------------------------------------------------------------
// tow_game_core
//   Tug-of-war game core. It takes the two raw push-buttons, synchronises them
//   and turns each press into a one-clock push. It runs the random-delay round
//   controller (WAIT -> GO -> MOVE), keeps score as a light position on the
//   track, and flashes the winning end LED before restarting the game.
//
// Ports
//   clk          system clock
//   rst          synchronous active-high reset
//   pbl, pbr     left / right buttons, raw asynchronous levels
//   leds_out     track LEDs, bit NUM_LEDS-1 is the left end
//   go           high while the GO window is open
//   winner       2'b01 left won, 2'b10 right won, 2'b00 none
//   tie          one-clock pulse when both players push in the same GO cycle
//   false_start  one-clock pulse when a single player pushes during WAIT
// ---------------------------------------------------------------------------
module tow_game_core #(
    parameter int NUM_LEDS    = 7,
    parameter int TICK_DIV    = 256,
    parameter int MIN_DELAY   = 16,
    parameter int DELAY_W     = 6,
    parameter int GO_TIMEOUT  = 255,
    parameter int WIN_TICKS   = 32,
    parameter int FALSE_START = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pbl,
    input  logic                pbr,
    output logic [NUM_LEDS-1:0] leds_out,
    output logic                go,
    output logic [1:0]          winner,
    output logic                tie,
    output logic                false_start
);

    localparam int POS_W = $clog2(NUM_LEDS);
    localparam int PRE_W = $clog2(TICK_DIV);
    localparam int DLY_W = $clog2(MIN_DELAY + (1 << DELAY_W));
    localparam int GO_W  = $clog2(GO_TIMEOUT + 1);
    localparam int WIN_W = $clog2(WIN_TICKS + 1);

    localparam logic [POS_W-1:0] POS_ZERO   = '0;
    localparam logic [POS_W-1:0] POS_ONE    = POS_W'(1);
    localparam logic [POS_W-1:0] POS_LAST   = POS_W'(NUM_LEDS - 1);
    localparam logic [POS_W-1:0] POS_CENTRE = POS_W'((NUM_LEDS - 1) / 2);
    localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(TICK_DIV - 1);
    localparam logic [DLY_W-1:0] DLY_MIN    = DLY_W'(MIN_DELAY);
    localparam logic [DLY_W-1:0] DLY_ONE    = DLY_W'(1);
    localparam logic [GO_W-1:0]  GO_LAST    = GO_W'(GO_TIMEOUT - 1);
    localparam logic [WIN_W-1:0] WIN_LAST   = WIN_W'(WIN_TICKS - 1);

    typedef enum logic [1:0] {
        S_WAIT = 2'd0,
        S_GO   = 2'd1,
        S_MOVE = 2'd2,
        S_WIN  = 2'd3
    } state_t;

    // -----------------------------------------------------------------------
    // Tick prescaler and free-running LFSR
    // -----------------------------------------------------------------------
    logic [PRE_W-1:0] presc_q;
    logic             tick;
    logic [15:0]      lfsr_q;
    logic             lfsr_fb;

    assign tick    = (presc_q == PRE_LAST);
    // Taps 16,14,13,11 (1-based); a maximal-length sequence that never
    // reaches zero from a non-zero seed.
    assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            lfsr_q  <= 16'hACE1;
        end else begin
            presc_q <= tick ? '0 : presc_q + PRE_W'(1);
            lfsr_q  <= {lfsr_q[14:0], lfsr_fb};
        end
    end

    // -----------------------------------------------------------------------
    // Button synchronisers: two flops, an edge-history flop, registered push.
    // Index 1 is the left button, index 0 the right button.
    // -----------------------------------------------------------------------
    logic [1:0] btn_raw;
    logic [1:0] push_w;
    logic       push_l;
    logic       push_r;

    assign btn_raw = {pbl, pbr};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            logic s1_q;
            logic s2_q;
            logic prev_q;
            logic push_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    s1_q   <= 1'b0;
                    s2_q   <= 1'b0;
                    prev_q <= 1'b0;
                    push_q <= 1'b0;
                end else begin
                    s1_q   <= btn_raw[gi];
                    s2_q   <= s1_q;
                    prev_q <= s2_q;
                    push_q <= s2_q & ~prev_q;
                end
            end

            assign push_w[gi] = push_q;
        end
    endgenerate

    assign push_l = push_w[1];
    assign push_r = push_w[0];

    // -----------------------------------------------------------------------
    // Game state
    // -----------------------------------------------------------------------
    state_t           state_q,   state_d;
    logic [POS_W-1:0] pos_q,     pos_d;
    logic [DLY_W-1:0] delay_q,   delay_d;
    logic [GO_W-1:0]  go_cnt_q,  go_cnt_d;
    logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
    logic             flash_q,   flash_d;
    logic [1:0]       winner_q,  winner_d;
    logic             tie_q,     tie_d;
    logic             fs_q,      fs_d;

    logic [DLY_W-1:0] delay_reload;
    logic [POS_W-1:0] pos_fs;

    // Fresh random delay, sampled whenever WAIT is (re)entered.
    assign delay_reload = DLY_MIN + DLY_W'(lfsr_q[DELAY_W-1:0]);

    // A false start hands one step to the opponent: left early moves the
    // light toward the right end (pos-1), right early toward the left end.
    assign pos_fs = push_l ? (pos_q - POS_ONE) : (pos_q + POS_ONE);

    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        delay_d   = delay_q;
        go_cnt_d  = go_cnt_q;
        win_cnt_d = win_cnt_q;
        flash_d   = flash_q;
        winner_d  = winner_q;
        tie_d     = 1'b0;
        fs_d      = 1'b0;

        unique case (state_q)
            S_WAIT: begin
                if ((FALSE_START != 0) && (push_l || push_r)) begin
                    // Any early push restarts the random wait; only a lone
                    // pusher is penalised.
                    delay_d = delay_reload;
                    if (push_l ^ push_r) begin
                        fs_d  = 1'b1;
                        pos_d = pos_fs;
                        if (pos_fs == POS_ZERO) begin
                            state_d   = S_WIN;
                            winner_d  = 2'b10;
                            flash_d   = 1'b1;
                            win_cnt_d = '0;
                        end else if (pos_fs == POS_LAST) begin
                            state_d   = S_WIN;
                            winner_d  = 2'b01;
                            flash_d   = 1'b1;
                            win_cnt_d = '0;
                        end
                    end
                end else if (tick) begin
                    // delay_q counts the ticks still to wait, so the last
                    // one opens GO rather than decrementing to zero.
                    if (delay_q <= DLY_ONE) begin
                        state_d  = S_GO;
                        go_cnt_d = '0;
                    end else begin
                        delay_d = delay_q - DLY_ONE;
                    end
                end
            end

            S_GO: begin
                // A push beats a timeout tick landing in the same cycle.
                if (push_l || push_r) begin
                    state_d = S_MOVE;
                    if (push_l && push_r) begin
                        tie_d = 1'b1;
                    end else if (push_l) begin
                        pos_d = pos_q + POS_ONE;
                    end else begin
                        pos_d = pos_q - POS_ONE;
                    end
                end else if (tick) begin
                    if (go_cnt_q == GO_LAST) begin
                        state_d = S_WAIT;
                        delay_d = delay_reload;
                    end else begin
                        go_cnt_d = go_cnt_q + GO_W'(1);
                    end
                end
            end

            S_MOVE: begin
                if (pos_q == POS_ZERO) begin
                    state_d   = S_WIN;
                    winner_d  = 2'b10;
                    flash_d   = 1'b1;
                    win_cnt_d = '0;
                end else if (pos_q == POS_LAST) begin
                    state_d   = S_WIN;
                    winner_d  = 2'b01;
                    flash_d   = 1'b1;
                    win_cnt_d = '0;
                end else begin
                    state_d = S_WAIT;
                    delay_d = delay_reload;
                end
            end

            S_WIN: begin
                if (tick) begin
                    if (win_cnt_q == WIN_LAST) begin
                        state_d  = S_WAIT;
                        pos_d    = POS_CENTRE;
                        winner_d = 2'b00;
                        flash_d  = 1'b0;
                        delay_d  = delay_reload;
                    end else begin
                        win_cnt_d = win_cnt_q + WIN_W'(1);
                        flash_d   = ~flash_q;
                    end
                end
            end

            default: begin
                state_d = S_WAIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_WAIT;
            pos_q     <= POS_CENTRE;
            delay_q   <= DLY_MIN;
            go_cnt_q  <= '0;
            win_cnt_q <= '0;
            flash_q   <= 1'b0;
            winner_q  <= 2'b00;
            tie_q     <= 1'b0;
            fs_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            delay_q   <= delay_d;
            go_cnt_q  <= go_cnt_d;
            win_cnt_q <= win_cnt_d;
            flash_q   <= flash_d;
            winner_q  <= winner_d;
            tie_q     <= tie_d;
            fs_q      <= fs_d;
        end
    end

    // -----------------------------------------------------------------------
    // LED drive
    // -----------------------------------------------------------------------
    logic [NUM_LEDS-1:0] pos_onehot;

    generate
        for (gi = 0; gi < NUM_LEDS; gi++) begin : g_onehot
            assign pos_onehot[gi] = (pos_q == POS_W'(gi));
        end
    endgenerate

    always_comb begin
        leds_out = '0;
        unique case (state_q)
            S_WAIT:  leds_out = '0;
            S_GO:    leds_out = pos_onehot;
            S_MOVE:  leds_out = pos_onehot;
            // pos sits on an end LED throughout WIN.
            S_WIN:   leds_out = flash_q ? pos_onehot : '0;
            default: leds_out = '0;
        endcase
    end

    assign go          = (state_q == S_GO);
    assign winner      = winner_q;
    assign tie         = tie_q;
    assign false_start = fs_q;

endmodule
